// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, FSM state type and byte/word helpers
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:13][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Byte a0 is row 0 of the column (most significant byte of the word)
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_key.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key
// Description : Combinational next-round-key generator for AES-128 / AES-256
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_key
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [KEY_BITS-1:0] rk_win,
    input  logic [3:0]          round,
    output logic [127:0]        rk,
    output logic [KEY_BITS-1:0] rk_win_next
);

    generate
        if (KEY_BITS == 128) begin : g_aes128
            logic [3:0]  w_rc_idx;
            logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
            always_comb begin
                w_rc_idx    = round - 4'd1;
                w_t         = sub_word(rot_word(rk_win[31:0])) ^ {RCON[w_rc_idx], 24'h0};
                w_n0        = rk_win[127:96] ^ w_t;
                w_n1        = rk_win[95:64]  ^ w_n0;
                w_n2        = rk_win[63:32]  ^ w_n1;
                w_n3        = rk_win[31:0]   ^ w_n2;
                rk          = {w_n0, w_n1, w_n2, w_n3};
                rk_win_next = rk;
            end
        end else begin : g_aes256
            logic [3:0]  w_rc_idx;
            logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
            always_comb begin
                // rcon only advances on even rounds, starting at round 2
                w_rc_idx = {1'b0, round[3:1]} - 4'd1;
                if (round[0])
                    w_t = sub_word(rk_win[31:0]);
                else
                    w_t = sub_word(rot_word(rk_win[31:0])) ^ {RCON[w_rc_idx], 24'h0};
                w_n0 = rk_win[255:224] ^ w_t;
                w_n1 = rk_win[223:192] ^ w_n0;
                w_n2 = rk_win[191:160] ^ w_n1;
                w_n3 = rk_win[159:128] ^ w_n2;
                if (round == 4'd1) begin
                    rk          = rk_win[127:0];
                    rk_win_next = rk_win;
                end else begin
                    rk          = {w_n0, w_n1, w_n2, w_n3};
                    rk_win_next = {rk_win[127:0], w_n0, w_n1, w_n2, w_n3};
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : aes_iter_core
// Description : Iterative AES-128/256 encryptor, one round per clock, on-the-fly
//               key expansion. Define AES_CTR_MODE_EN for counter mode.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_load,
`ifdef AES_CTR_MODE_EN
    input  logic [127:0]        iv_in,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                busy
);

    localparam int         NK   = KEY_BITS / 32;
    localparam int         NR   = NK + 6;
    localparam logic [3:0] C_NR = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_iter_core: KEY_BITS must be 128 or 256");
        end
    endgenerate

    state_e              r_fsm, w_fsm_next;
    logic [127:0]        r_state;
    logic [3:0]          r_round_cnt;
    logic [KEY_BITS-1:0] r_key;
    logic [KEY_BITS-1:0] r_rk;
    logic [KEY_BITS-1:0] w_rk_win_next;
    logic [127:0]        w_rk, w_sb, w_sr, w_mc, w_round, w_block;
    logic                w_last, w_accept;

`ifdef AES_CTR_MODE_EN
    logic [127:0] r_ctr, r_din;
    assign w_block  = r_ctr;
    assign data_out = (r_fsm == DONE) ? (r_din ^ r_state) : '0;
`else
    assign w_block  = data_in;
    assign data_out = (r_fsm == DONE) ? r_state : '0;
`endif

    assign w_last   = (r_round_cnt == C_NR);
    assign w_accept = in_valid & in_ready;

    aes_round_key #(.KEY_BITS(KEY_BITS)) u_round_key (
        .rk_win      (r_rk),
        .round       (r_round_cnt),
        .rk          (w_rk),
        .rk_win_next (w_rk_win_next)
    );

    // Byte i of the state sits at bits [127-8i -: 8]; column c = bytes 4c..4c+3
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++)
            w_sb[127-8*i -: 8] = SBOX[r_state[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++)
            w_mc[127-32*c -: 32] = mix_column(w_sr[127-32*c -: 32]);
        w_round = (w_last ? w_sr : w_mc) ^ w_rk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (r_fsm)
            IDLE: begin
                busy     = 1'b0;
                in_ready = ~key_load & ~rst;
                if (in_valid & in_ready) w_fsm_next = ROUND;
            end
            ROUND: begin
                if (w_last) w_fsm_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = IDLE;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= '0;
            r_round_cnt <= '0;
            r_key       <= '0;
            r_rk        <= '0;
`ifdef AES_CTR_MODE_EN
            r_ctr       <= '0;
            r_din       <= '0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (key_load) begin
                        r_key <= key_in;
`ifdef AES_CTR_MODE_EN
                        r_ctr <= iv_in;
`endif
                    end else if (w_accept) begin
                        r_state     <= w_block ^ r_key[KEY_BITS-1 -: 128];
                        r_rk        <= r_key;
                        r_round_cnt <= 4'd1;
`ifdef AES_CTR_MODE_EN
                        r_din       <= data_in;
`endif
                    end
                end
                ROUND: begin
                    r_state     <= w_round;
                    r_rk        <= w_rk_win_next;
                    r_round_cnt <= r_round_cnt + 4'd1;
                end
                DONE: begin
`ifdef AES_CTR_MODE_EN
                    if (out_ready) r_ctr <= r_ctr + 128'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_aes_iter_core
// Description : Directed-vector bench for aes_iter_core (AES-128 and AES-256)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_iter_core;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic [255:0] key_s = '0;
    logic         key_load_s = 1'b0, in_valid_s = 1'b0, out_ready_s = 1'b0;
    logic [127:0] data_in_s = '0;
`ifdef AES_CTR_MODE_EN
    logic [127:0] iv_s = '0;
`endif

    logic         in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [127:0] data_out0, data_out1;
    logic         ir, ov, bz;
    logic [127:0] dout;

    assign ir   = sel ? in_ready1  : in_ready0;
    assign ov   = sel ? out_valid1 : out_valid0;
    assign bz   = sel ? busy1      : busy0;
    assign dout = sel ? data_out1  : data_out0;

    aes_iter_core #(.KEY_BITS(128)) u_dut128 (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_s[255:128]),
        .key_load  (key_load_s & ~sel),
`ifdef AES_CTR_MODE_EN
        .iv_in     (iv_s),
`endif
        .in_valid  (in_valid_s & ~sel),
        .in_ready  (in_ready0),
        .data_in   (data_in_s),
        .out_valid (out_valid0),
        .out_ready (out_ready_s & ~sel),
        .data_out  (data_out0),
        .busy      (busy0)
    );

    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_s),
        .key_load  (key_load_s & sel),
`ifdef AES_CTR_MODE_EN
        .iv_in     (iv_s),
`endif
        .in_valid  (in_valid_s & sel),
        .in_ready  (in_ready1),
        .data_in   (data_in_s),
        .out_valid (out_valid1),
        .out_ready (out_ready_s & sel),
        .data_out  (data_out1),
        .busy      (busy1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic load_key(input logic [255:0] k);
        @(negedge clk);
        key_s      = k;
        key_load_s = 1'b1;
        @(negedge clk);
        key_load_s = 1'b0;
    endtask

    // Returns 1ns after the accept edge
    task automatic accept(input logic [127:0] pt);
        int n;
        @(negedge clk);
        data_in_s  = pt;
        in_valid_s = 1'b1;
        #1;
        n = 0;
        while (!ir && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_ready", 128'(ir), 128'd1);
        @(posedge clk);
        #1 in_valid_s = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen; ends on that falling edge
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ov && cyc < 60);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready_s = 1'b1;
        @(posedge clk);
        #1 out_ready_s = 1'b0;
        check("handshake_clears_valid", 128'(ov), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(ir), 128'd0);
        check("rst_out_valid", 128'(ov), 128'd0);
        check("rst_busy", 128'(bz), 128'd0);
        check("rst_data_out", dout, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 128'(ir), 128'd1);

`ifndef AES_CTR_MODE_EN
        // key_load together with in_valid: key captured, block refused
        @(negedge clk);
        key_s      = {K1, 128'h0};
        key_load_s = 1'b1;
        data_in_s  = PT1;
        in_valid_s = 1'b1;
        #1;
        check("keyload_blocks_ready", 128'(ir), 128'd0);
        @(negedge clk);
        key_load_s = 1'b0;
        in_valid_s = 1'b0;
        #1;
        check("keyload_not_accepted", 128'(bz), 128'd0);

        accept(PT1);
        check("busy_in_round", 128'(bz), 128'd1);
        wait_out(cyc);
        check("lat128", 128'(cyc), 128'd11);
        check("ct_fips128", dout, CT1);
        handshake();

        // Output held while the sink stalls
        load_key({K2, 128'h0});
        accept(PT2);
        wait_out(cyc);
        check("ct_k2", dout, CT2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", dout, CT2);
            check("hold_in_ready", 128'(ir), 128'd0);
        end
        handshake();

        // Back-to-back blocks: NR+2 cycles per block
        @(negedge clk);
        data_in_s   = PT2;
        in_valid_s  = 1'b1;
        out_ready_s = 1'b1;
        wait_out(cyc);
        check("b2b_first", dout, CT2);
        wait_out(cyc);
        in_valid_s = 1'b0;
        check("b2b_period", 128'(cyc), 128'd12);
        check("b2b_second", dout, CT2);
        @(posedge clk);
        #1 out_ready_s = 1'b0;

        // key_load mid-block is ignored
        accept(PT2);
        repeat (3) @(negedge clk);
        key_s      = {K1, 128'h0};
        key_load_s = 1'b1;
        @(negedge clk);
        key_load_s = 1'b0;
        wait_out(cyc);
        check("keyload_ignored_cur", dout, CT2);
        handshake();
        accept(PT2);
        wait_out(cyc);
        check("keyload_ignored_next", dout, CT2);
        handshake();

        // Reset mid-block
        accept(PT2);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(ov), 128'd0);
        check("midrst_data_out", dout, 128'd0);
        check("midrst_busy", 128'(bz), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 128'(ir), 128'd1);
        load_key({K2, 128'h0});
        accept(PT2);
        wait_out(cyc);
        check("after_rst_ct", dout, CT2);
        handshake();

        // AES-256 instance
        sel = 1'b1;
        load_key(K256);
        accept(PT2);
        wait_out(cyc);
        check("lat256", 128'(cyc), 128'd15);
        check("ct_fips256", dout, CT256);
        handshake();
        sel = 1'b0;
`else
        // Counter-mode vectors: two blocks from the same IV stream
        iv_s = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        load_key({K1, 128'h0});
        accept(128'h6bc1bee22e409f96e93d7e117393172a);
        wait_out(cyc);
        check("ctr_lat", 128'(cyc), 128'd11);
        check("ctr_blk1", dout, 128'h874d6191b620e3261bef6864990db6ce);
        handshake();
        accept(128'hae2d8a571e03ac9c9eb76fac45af8e51);
        wait_out(cyc);
        check("ctr_blk2", dout, 128'h9806f66b7970fdff8617187bb9fffdff);
        handshake();

        // Counter wrap: second block encrypts counter zero under a zero key
        iv_s = '1;
        load_key('0);
        accept('0);
        wait_out(cyc);
        check("ctr_wrap_valid", 128'(ov), 128'd1);
        handshake();
        accept('0);
        wait_out(cyc);
        check("ctr_wrap_zero", dout, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        handshake();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Iterative AES encryption core: one AES round per clock on a single 128-bit state register, with the round key expanded on the fly.
- Successor to the fully unrolled combinational AES-128 encryptor. Parametrised for AES-128 or AES-256, with valid/ready handshakes on input and output.
- Sits between the block-input buffer and the ciphertext sink of the crypto datapath.

Parameters:
- KEY_BITS, 128, cipher key width; legal values 128 or 256. NR = 10 or 14 rounds respectively.
- NK, KEY_BITS/32, number of key words. Derived; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  KEY_BITS  cipher key, bit 0 = MSB of byte 0.
- key_load  in  1  pulse; captures key_in into key_reg. Honoured only in IDLE, ignored otherwise.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  core can accept a block; high only in IDLE and not in the key_load cycle.
- data_in  in  128  plaintext [0:127]; byte i = bits 8i..8i+7, FIPS-197 column-major order.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  sink accepts ciphertext.
- data_out  out  128  ciphertext, same byte order as data_in.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset values: in_ready=0 during reset, 1 after reset releases (IDLE); out_valid=0; busy=0; data_out=0. state, round_cnt, key_reg and rk_reg are all cleared.
- FSM states IDLE, ROUND, DONE.
- IDLE -> ROUND on in_valid & in_ready. Same edge: state <= data_in ^ key_reg[0:127]; round key generator loaded from key_reg; round_cnt <= 1.
- ROUND, each cycle: state <= SubBytes, ShiftRows, MixColumns, AddRoundKey(rk). MixColumns is skipped when round_cnt == NR. round_cnt increments.
- ROUND -> DONE after round NR completes. Latency: accept edge T, out_valid high from T+NR+1 (11 cycles for AES-128, 15 for AES-256).
- DONE: data_out = state and out_valid=1, held stable until out_ready. On out_valid & out_ready -> IDLE. Back-to-back throughput is one block per NR+2 cycles.
- Key schedule, AES-128: rk_next = expand(rk, rcon). rcon sequence 01,02,04,08,10,20,40,80,1b,36.
- Key schedule, AES-256: a 256-bit window is held. Even rounds use RotWord+SubWord+rcon; odd rounds use SubWord only. Round 1 uses key_reg[128:255] directly. rcon advances every second round.
- key_reg is never modified by expansion; every block restarts from it.
- key_load and in_valid in the same IDLE cycle: key is captured and the block is not accepted (in_ready=0 that cycle).
- key_load in ROUND or DONE: ignored; key_reg unchanged.
- in_valid outside IDLE: ignored, not queued.
- rst asserted mid-operation: immediate return to reset values; the in-flight block is discarded and the key must be reloaded.
- KEY_BITS not in {128,256}: elaboration error.

Optional Feature:
- Macro AES_CTR_MODE_EN.
- When defined:
  - Adds port iv_in (in, 128), captured into ctr_reg with key_load.
  - The core encrypts ctr_reg, not data_in. data_out = data_in_reg ^ E(ctr_reg); data_in is registered at accept.
  - ctr_reg increments by 1 mod 2^128 on each output handshake. Wrap ff..ff -> 00..00 is silent.
- When undefined: ECB only; no iv_in port, no ctr_reg.

Decomposition:
- Package aes_pkg holds:
  - SBOX constant array (256 x 8);
  - RCON array (14 x 8);
  - state_e enum {IDLE, ROUND, DONE};
  - functions xtime, sub_word, rot_word, mix_column (32-bit).
- One sub-module aes_round_key: combinational next-round-key generator parametrised by KEY_BITS, taking rk window and round index. SubBytes, ShiftRows and MixColumns stay inline in aes_iter_core.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> data_out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 cycles after accept.
- KEY_BITS=256, key 000102..1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 at accept+15.
- KEY_BITS=128, key 000102..0f, same pt, out_ready held low 5 cycles -> 69c4e0d86a7b0430d8cdb78070b4c55a held stable, in_ready=0 throughout; two back-to-back blocks give identical ciphertext.
- key_load with new key at accept+4 -> ignored; current result unchanged; next block uses the old key.
- rst pulsed at accept+6 -> out_valid=0, data_out=0, in_ready=1 next cycle; key reload plus resubmitted block gives the correct result.
- AES_CTR_MODE_EN, AES-128 vector key, iv ff..ff, data_in 0 -> data_out = E(ff..ff); next block encrypts counter 00..00.
